zpu_int_ctrl: RTL and testbench

ZPU_INT_CTRL -- requirements
Module: zpu_int_ctrl

---
 rtl/zpu_int_ctrl_if.sv | 22 ++
 rtl/zpu_int_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_zpu_int_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zpu_int_ctrl_if.sv
// Wishbone classic configuration bus bundle for the interrupt controller.
// Carries only the slave-side bus signals; no logic and no latency of its own.
// Backpressure: none, the slave acks every strobe one cycle later.
interface zpu_int_ctrl_if;
    logic [5:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/zpu_int_ctrl.sv
// Vectored, non-nesting interrupt controller for the ZPU with a Wishbone config port.
// Latency: irq edge -> PENDING in 3 clocks, PENDING -> cpu_irq 1 clock; bus ack 1 clock.
// Backpressure: a request is held until interrutack; new sources wait in PENDING.
module zpu_int_ctrl #(
    parameter int pc_bit_size = 25,
    parameter int num_irq     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    zpu_int_ctrl_if.slave          wb,
    input  logic [num_irq-1:0]     irq_in,
    output logic                   cpu_irq,
    output logic [pc_bit_size-1:0] interuptadr,
    input  logic                   interrutack,
    input  logic                   exitint
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t                   state_q;
    logic [2:0]               active_q;
    logic [pc_bit_size-1:0]   interuptadr_q;
    logic                     cpu_irq_q;

    logic [num_irq-1:0]       sync1_q, sync2_q, dly_q;
    logic [1:0]               arm_cnt_q;
    logic                     armed;
    logic [num_irq-1:0]       rise;

    logic [num_irq-1:0]       enable_q;
    logic [num_irq-1:0]       pending_q, pending_d;
    logic                     gen_q;
    logic [pc_bit_size-1:0]   vector_q [num_irq];

    logic                     ack_q;
    logic [31:0]              dat_q;
    logic [31:0]              rd_dat;
    logic                     bus_req, wr_en;
    logic [3:0]               idx;
    logic                     busy;

    logic [num_irq-1:0]       w1c_mask, ack_clr;
    logic                     sel_vld;
    logic [2:0]               sel_idx;
    logic [pc_bit_size-1:0]   sel_vec;

    logic                     unused_ok;
    assign unused_ok = ^{wb.wb_adr_i[1:0], wb.wb_dat_i};

    assign bus_req = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign wr_en   = bus_req & wb.wb_we_i;
    assign idx     = wb.wb_adr_i[5:2];
    assign busy    = (state_q != ST_IDLE);

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign cpu_irq     = cpu_irq_q;
    assign interuptadr = interuptadr_q;

    // Synchronizer plus delay flop; edge detection stays off until the pipe has
    // refilled after reset so levels already high never look like fresh edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            dly_q     <= '0;
            arm_cnt_q <= 2'd0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            if (!armed) begin
                arm_cnt_q <= arm_cnt_q + 2'd1;
            end
        end
    end

    assign armed = (arm_cnt_q == 2'd3);
    assign rise  = armed ? (sync2_q & ~dly_q) : '0;

    // Clear sources for PENDING: bus write-1-to-clear and CPU acknowledge of the active source.
    always_comb begin
        w1c_mask = '0;
        ack_clr  = '0;
        if (wr_en && idx == 4'd1) begin
            w1c_mask = wb.wb_dat_i[num_irq-1:0];
        end
        for (int n = 0; n < num_irq; n++) begin
            ack_clr[n] = (state_q == ST_REQ) && interrutack && (active_q == 3'(n));
        end
        pending_d = (pending_q & ~w1c_mask & ~ack_clr) | rise;
    end

    // Pending latch; a fresh edge wins over any clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Lowest-numbered enabled pending source and its handler address.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = 3'd0;
        sel_vec = '0;
        for (int n = num_irq - 1; n >= 0; n--) begin
            if (pending_q[n] && enable_q[n]) begin
                sel_vld = 1'b1;
                sel_idx = 3'(n);
                sel_vec = vector_q[n];
            end
        end
    end

    // Configuration registers written through the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q <= '0;
            gen_q    <= 1'b0;
            for (int n = 0; n < num_irq; n++) begin
                vector_q[n] <= '0;
            end
        end else if (wr_en) begin
            if (idx == 4'd0) begin
                enable_q <= wb.wb_dat_i[num_irq-1:0];
            end
            if (idx == 4'd2) begin
                gen_q <= wb.wb_dat_i[0];
            end
            for (int n = 0; n < num_irq; n++) begin
                if (idx == 4'(8 + n)) begin
                    vector_q[n] <= wb.wb_dat_i[pc_bit_size-1:0];
                end
            end
        end
    end

    // Read data mux; unmapped indices read zero.
    always_comb begin
        rd_dat = '0;
        case (idx)
            4'd0:    rd_dat = 32'(enable_q);
            4'd1:    rd_dat = 32'(pending_q);
            4'd2:    rd_dat = {31'd0, gen_q};
            4'd3:    rd_dat = {23'd0, busy, 5'd0, active_q};
            default: begin
                for (int n = 0; n < num_irq; n++) begin
                    if (idx == 4'(8 + n)) begin
                        rd_dat = 32'(vector_q[n]);
                    end
                end
            end
        endcase
    end

    // Single-cycle registered ack with read data captured at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= bus_req;
            if (bus_req) begin
                dat_q <= rd_dat;
            end
        end
    end

    // Request/service FSM; address and active source are frozen for the whole request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            active_q      <= 3'd0;
            interuptadr_q <= '0;
            cpu_irq_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gen_q && sel_vld) begin
                        active_q      <= sel_idx;
                        interuptadr_q <= sel_vec;
                        cpu_irq_q     <= 1'b1;
                        state_q       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (interrutack) begin
                        cpu_irq_q <= 1'b0;
                        state_q   <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (exitint) begin
                        active_q <= 3'd0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    cpu_irq_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zpu_int_ctrl.sv
// Self-checking bench for zpu_int_ctrl: directed scenarios plus randomized rounds
// scored against a register/priority model kept in plain arrays.
module tb_zpu_int_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  irq_in = '0;
    logic        cpu_irq;
    logic [24:0] interuptadr;
    logic        interrutack = 1'b0;
    logic        exitint = 1'b0;

    zpu_int_ctrl_if wbif ();

    zpu_int_ctrl #(.pc_bit_size(25), .num_irq(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb          (wbif.slave),
        .irq_in      (irq_in),
        .cpu_irq     (cpu_irq),
        .interuptadr (interuptadr),
        .interrutack (interrutack),
        .exitint     (exitint)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  m_pend, m_en;
    logic [24:0] m_vec [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [3:0] idx, input logic [31:0] d,
                           output logic [31:0] q);
        bit got;
        got = 0;
        wbif.wb_adr_i = {idx, 2'b00};
        wbif.wb_dat_i = d;
        wbif.wb_we_i  = we;
        wbif.wb_cyc_i = 1'b1;
        wbif.wb_stb_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (wbif.wb_ack_o) begin
                got = 1;
                break;
            end
        end
        q = wbif.wb_dat_o;
        wbif.wb_cyc_i = 1'b0;
        wbif.wb_stb_i = 1'b0;
        wbif.wb_we_i  = 1'b0;
        if (!got) chk("wb_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr(input logic [3:0] idx, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, idx, d, q);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] idx, input logic [31:0] exp);
        logic [31:0] q;
        wb_xfer(1'b0, idx, 32'd0, q);
        chk(tag, q, exp);
    endtask

    task automatic wait_irq(input string tag, input int bound);
        bit ok;
        ok = 0;
        for (int i = 0; i <= bound; i++) begin
            if (cpu_irq) begin
                ok = 1;
                break;
            end
            if (i < bound) tick(1);
        end
        if (!ok) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic pulse_irq(input logic [7:0] mask);
        irq_in = irq_in | mask;
        tick(2);
        irq_in = irq_in & ~mask;
    endtask

    task automatic do_ack();
        interrutack = 1'b1;
        tick(1);
        interrutack = 1'b0;
    endtask

    task automatic do_exit();
        exitint = 1'b1;
        tick(1);
        exitint = 1'b0;
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        int src;
        logic [24:0] v;
        logic [7:0]  mask;
        wbif.wb_adr_i = '0;
        wbif.wb_dat_i = '0;
        wbif.wb_we_i  = 1'b0;
        wbif.wb_cyc_i = 1'b0;
        wbif.wb_stb_i = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Reset state
        chk("rst_cpu_irq", 32'(cpu_irq), 32'd0);
        chk("rst_ack", 32'(wbif.wb_ack_o), 32'd0);
        chk("rst_adr", 32'(interuptadr), 32'd0);
        rd_chk("rst_enable", 4'd0, 32'd0);
        rd_chk("rst_pending", 4'd1, 32'd0);
        rd_chk("rst_ctrl", 4'd2, 32'd0);
        rd_chk("rst_status", 4'd3, 32'd0);
        rd_chk("rst_vec0", 4'd8, 32'd0);

        // Basic configuration and single interrupt
        wr(4'd10, 32'h100);
        wr(4'd0, 32'h04);
        wr(4'd2, 32'h1);
        pulse_irq(8'h04);
        wait_irq("cfg_irq_latency", 3);
        chk("cfg_adr", 32'(interuptadr), 32'h100);
        do_ack();
        chk("cfg_irq_drop", 32'(cpu_irq), 32'd0);
        rd_chk("cfg_pending", 4'd1, 32'd0);
        rd_chk("cfg_status_svc", 4'd3, 32'h102);
        do_exit();
        rd_chk("cfg_status_idle", 4'd3, 32'h000);

        // Priority between simultaneous edges
        wr(4'd9, 32'h111);
        wr(4'd13, 32'h555);
        wr(4'd0, 32'hFF);
        pulse_irq(8'h22);
        wait_irq("prio_irq1", 6);
        chk("prio_adr1", 32'(interuptadr), 32'h111);
        rd_chk("prio_status_req", 4'd3, 32'h101);
        do_ack();
        do_exit();
        chk("prio_gap", 32'(cpu_irq), 32'd0);
        tick(1);
        chk("prio_irq5_next", 32'(cpu_irq), 32'd1);
        chk("prio_adr5", 32'(interuptadr), 32'h555);
        do_ack();
        do_exit();
        tick(2);

        // No nesting
        wr(4'd11, 32'h333);
        wr(4'd8, 32'h0AA);
        pulse_irq(8'h08);
        wait_irq("nest_irq3", 6);
        chk("nest_adr3", 32'(interuptadr), 32'h333);
        do_ack();
        pulse_irq(8'h01);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (cpu_irq) seen = 1;
            tick(1);
        end
        chk("nest_hold", 32'(seen), 32'd0);
        rd_chk("nest_status", 4'd3, 32'h103);
        do_exit();
        wait_irq("nest_irq0", 3);
        chk("nest_adr0", 32'(interuptadr), 32'h0AA);
        do_ack();
        do_exit();
        tick(2);

        // Global enable gating
        wr(4'd2, 32'h0);
        wr(4'd0, 32'h08);
        pulse_irq(8'h08);
        tick(6);
        rd_chk("gate_pending", 4'd1, 32'h08);
        chk("gate_off", 32'(cpu_irq), 32'd0);
        wr(4'd2, 32'h1);
        chk("gate_ack_edge", 32'(cpu_irq), 32'd0);
        wait_irq("gate_on", 2);
        wr(4'd1, 32'h08);
        wr(4'd11, 32'h777);
        wr(4'd2, 32'h0);
        chk("gate_req_held", 32'(cpu_irq), 32'd1);
        chk("gate_adr_stable", 32'(interuptadr), 32'h333);
        do_ack();
        do_exit();
        tick(2);

        // Bus behaviour: back-to-back strobes, unmapped index, set/clear collision
        wbif.wb_adr_i = 6'd0;
        wbif.wb_cyc_i = 1'b1;
        wbif.wb_stb_i = 1'b1;
        chk("bus_ack_0", 32'(wbif.wb_ack_o), 32'd0);
        tick(1);
        chk("bus_ack_1", 32'(wbif.wb_ack_o), 32'd1);
        tick(1);
        chk("bus_ack_2", 32'(wbif.wb_ack_o), 32'd0);
        tick(1);
        chk("bus_ack_3", 32'(wbif.wb_ack_o), 32'd1);
        wbif.wb_cyc_i = 1'b0;
        wbif.wb_stb_i = 1'b0;
        tick(1);
        wr(4'd5, 32'hDEADBEEF);
        rd_chk("bus_idx5", 4'd5, 32'd0);
        wr(4'd0, 32'h0);
        wr(4'd1, 32'hFF);
        tick(2);
        irq_in[6] = 1'b1;
        tick(2);
        wr(4'd1, 32'h40);
        irq_in[6] = 1'b0;
        rd_chk("bus_collision", 4'd1, 32'h40);
        wr(4'd1, 32'h40);
        rd_chk("bus_w1c", 4'd1, 32'h00);

        // Reset in the middle of a request, with the source level held high
        wr(4'd8, 32'h0CC);
        wr(4'd0, 32'h01);
        wr(4'd2, 32'h1);
        irq_in[0] = 1'b1;
        wait_irq("rst_req", 6);
        rst = 1'b1;
        #1;
        chk("rst_async_drop", 32'(cpu_irq), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        rd_chk("rst2_enable", 4'd0, 32'd0);
        rd_chk("rst2_ctrl", 4'd2, 32'd0);
        rd_chk("rst2_vec0", 4'd8, 32'd0);
        wr(4'd0, 32'h01);
        wr(4'd2, 32'h1);
        tick(10);
        chk("rst2_no_req", 32'(cpu_irq), 32'd0);
        rd_chk("rst2_pending", 4'd1, 32'd0);
        rd_chk("rst2_status", 4'd3, 32'd0);
        irq_in[0] = 1'b0;
        wr(4'd2, 32'h0);
        tick(3);

        // Randomized rounds against the model
        m_pend = '0;
        for (int r = 0; r < 20; r++) begin
            m_en = 8'($urandom_range(0, 255));
            for (int i = 0; i < 8; i++) begin
                m_vec[i] = 25'($urandom);
                wr(4'(8 + i), {7'd0, m_vec[i]});
            end
            wr(4'd0, {24'd0, m_en});
            mask = 8'($urandom_range(1, 255));
            pulse_irq(mask);
            m_pend = m_pend | mask;
            tick(5);
            rd_chk("rnd_pending", 4'd1, {24'd0, m_pend});
            rd_chk("rnd_enable", 4'd0, {24'd0, m_en});
            src = $urandom_range(0, 7);
            rd_chk("rnd_vec", 4'(8 + src), {7'd0, m_vec[src]});
            wr(4'd2, 32'h1);
            while (lowest(m_pend & m_en) >= 0) begin
                src = lowest(m_pend & m_en);
                v = m_vec[src];
                wait_irq("rnd_irq", 6);
                if (!cpu_irq) break;
                chk("rnd_adr", 32'(interuptadr), {7'd0, v});
                rd_chk("rnd_status", 4'd3, 32'h100 | 32'(src));
                do_ack();
                m_pend[src] = 1'b0;
                do_exit();
            end
            tick(3);
            chk("rnd_idle", 32'(cpu_irq), 32'd0);
            wr(4'd2, 32'h0);
            rd_chk("rnd_left", 4'd1, {24'd0, m_pend});
            if (r % 3 == 2) begin
                wr(4'd1, 32'hFF);
                m_pend = '0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
